// File: rtl/wb_led_gpio.sv
// Wishbone GPIO/LED driver: direction/output/blink registers, prescaled blink tick, synchronised pin readback.
// Define LED_GPIO_IRQ_EN to add the pin-change interrupt (ISR/IER registers, irq_o).
module wb_led_gpio #(
  parameter int N       = 8,
  parameter int PRESC_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  inout  wire  [N-1:0]  led,
  output logic          irq_o
);

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_PIN   = 3'd2;
  localparam logic [2:0] REG_BLINK = 3'd3;
  localparam logic [2:0] REG_PRESC = 3'd4;
  localparam logic [2:0] REG_ISR   = 3'd5;
  localparam logic [2:0] REG_IER   = 3'd6;

  // Expand the four byte enables into a 32-bit bit-write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  logic [N-1:0]       out_q, out_d;
  logic [N-1:0]       dir_q, dir_d;
  logic [N-1:0]       blink_q, blink_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       sync1_q, sync2_q;
  logic               ack_q;
  logic [31:0]        dat_q, dat_d;

  logic               req_s;
  logic               wr_s;
  logic [2:0]         idx_s;
  logic [31:0]        bmask_s;
  logic [N-1:0]       wmask_s;
  logic [N-1:0]       wdat_s;
  logic [PRESC_W-1:0] pmask_s;
  logic [PRESC_W-1:0] pdat_s;
  logic               tick_s;
  logic [N-1:0]       tog_s;
  logic [N-1:0]       out_tog_s;
  logic               we_out_s, we_dir_s, we_blink_s, we_presc_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  assign req_s      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_s       = req_s & wb_we_i;
  assign idx_s      = wb_adr_i[4:2];
  assign bmask_s    = lane_mask(wb_sel_i);
  assign wmask_s    = bmask_s[N-1:0];
  assign wdat_s     = wb_dat_i[N-1:0];
  assign pmask_s    = bmask_s[PRESC_W-1:0];
  assign pdat_s     = wb_dat_i[PRESC_W-1:0];
  assign we_out_s   = wr_s && (idx_s == REG_OUT);
  assign we_dir_s   = wr_s && (idx_s == REG_DIR);
  assign we_blink_s = wr_s && (idx_s == REG_BLINK);
  assign we_presc_s = wr_s && (idx_s == REG_PRESC);
  assign unused_s   = ^{wb_adr_i[1:0], wb_dat_i, bmask_s};

  assign tick_s    = (presc_q != {PRESC_W{1'b0}}) && (cnt_q == presc_q);
  assign tog_s     = tick_s ? blink_q : {N{1'b0}};
  assign out_tog_s = out_q ^ tog_s;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pin
      assign led[gi] = dir_q[gi] ? out_q[gi] : 1'bz;
    end
  endgenerate

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

`ifdef LED_GPIO_IRQ_EN
  logic [N-1:0] sync3_q;
  logic [N-1:0] isr_q, isr_d;
  logic [N-1:0] ier_q, ier_d;
  logic         irq_q;
  logic         we_isr_s, we_ier_s;
  logic [N-1:0] w1c_s;
  logic [N-1:0] chg_s;

  assign we_isr_s = wr_s && (idx_s == REG_ISR);
  assign we_ier_s = wr_s && (idx_s == REG_IER);
  assign w1c_s    = we_isr_s ? (wdat_s & wmask_s) : {N{1'b0}};
  assign chg_s    = sync2_q ^ sync3_q;
  assign irq_o    = irq_q;

  // Interrupt next state: a fresh pin change outranks a same-cycle clear.
  always_comb begin
    isr_d = (isr_q & ~w1c_s) | chg_s;
    ier_d = we_ier_s ? ((ier_q & ~wmask_s) | (wdat_s & wmask_s)) : ier_q;
  end

  // Interrupt state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync3_q <= {N{1'b0}};
      isr_q   <= {N{1'b0}};
      ier_q   <= {N{1'b0}};
      irq_q   <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      isr_q   <= isr_d;
      ier_q   <= ier_d;
      irq_q   <= |(isr_q & ier_q);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  // Register read multiplexer; unused bits and unmapped slots read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (idx_s)
      REG_OUT:   rdata_s[N-1:0]       = out_q;
      REG_DIR:   rdata_s[N-1:0]       = dir_q;
      REG_PIN:   rdata_s[N-1:0]       = sync2_q;
      REG_BLINK: rdata_s[N-1:0]       = blink_q;
      REG_PRESC: rdata_s[PRESC_W-1:0] = presc_q;
`ifdef LED_GPIO_IRQ_EN
      REG_ISR:   rdata_s[N-1:0]       = isr_q;
      REG_IER:   rdata_s[N-1:0]       = ier_q;
`endif
      default:   rdata_s              = 32'd0;
    endcase
  end

  // Register next state; a CPU write to OUT overrides the blink toggle on written lanes.
  always_comb begin
    out_d   = we_out_s ? ((out_tog_s & ~wmask_s) | (wdat_s & wmask_s)) : out_tog_s;
    dir_d   = we_dir_s ? ((dir_q & ~wmask_s) | (wdat_s & wmask_s)) : dir_q;
    blink_d = we_blink_s ? ((blink_q & ~wmask_s) | (wdat_s & wmask_s)) : blink_q;
    presc_d = we_presc_s ? ((presc_q & ~pmask_s) | (pdat_s & pmask_s)) : presc_q;
    if (we_presc_s || tick_s || (presc_q == {PRESC_W{1'b0}})) begin
      cnt_d = {PRESC_W{1'b0}};
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
    if (req_s && !wb_we_i) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'd0;
    end
  end

  // Main state registers, bus handshake and pin synchroniser.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q   <= {N{1'b0}};
      dir_q   <= {N{1'b0}};
      blink_q <= {N{1'b0}};
      presc_q <= {PRESC_W{1'b0}};
      cnt_q   <= {PRESC_W{1'b0}};
      sync1_q <= {N{1'b0}};
      sync2_q <= {N{1'b0}};
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      blink_q <= blink_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      sync1_q <= led;
      sync2_q <= sync1_q;
      ack_q   <= req_s;
      dat_q   <= dat_d;
    end
  end

endmodule
